// File: rtl/accelerator_job_launcher.sv
// Bus initiator that runs one accelerator job per start pulse: acquire a job
// slot (retrying while busy), write the job registers, commit/trigger, then
// wait for the end-of-job event and report the acquired job ID.
module accelerator_job_launcher #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned N_REGS     = 13,
  parameter int unsigned RETRY_WAIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N_REGS*32-1:0]  job_regs_i,
  input  logic                  evt_i,
  output logic                  periph_req_o,
  input  logic                  periph_gnt_i,
  output logic [31:0]           periph_add_o,
  output logic                  periph_wen_o,
  output logic [3:0]            periph_be_o,
  output logic [31:0]           periph_data_o,
  input  logic [31:0]           periph_r_data_i,
  input  logic                  periph_r_valid_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            job_id_o
);

  localparam int unsigned IdxW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CntW = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

  localparam logic [31:0]     AcqAddr  = BASE_ADDR + 32'h04;
  localparam logic [31:0]     TrigAddr = BASE_ADDR;
  localparam logic [31:0]     RegBase  = BASE_ADDR + 32'h40;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REGS - 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(RETRY_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAcqReq,
    StAcqRsp,
    StRetry,
    StWrReg,
    StTrigger,
    StWaitEvt,
    StDone
  } state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d, idx_nxt;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [N_REGS-1:0][31:0]  regs_q, regs_d;
  logic                     req_q, req_d;
  logic [31:0]              add_q, add_d;
  logic                     wen_q, wen_d;
  logic [31:0]              data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [7:0]               job_id_q, job_id_d;

  assign idx_nxt = idx_q + IdxW'(1);

  // Next-state and next-output logic; outputs are registered from the next state
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    regs_d   = regs_q;
    add_d    = add_q;
    wen_d    = wen_q;
    data_d   = data_q;
    job_id_d = job_id_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          regs_d  = job_regs_i;
          state_d = StAcqReq;
          add_d   = AcqAddr;
          wen_d   = 1'b1;
          data_d  = 32'h0;
        end
      end
      StAcqReq: begin
        if (periph_gnt_i) state_d = StAcqRsp;
      end
      StAcqRsp: begin
        if (periph_r_valid_i) begin
          if (periph_r_data_i[31]) begin
            state_d = StRetry;
            cnt_d   = '0;
          end else begin
            job_id_d = periph_r_data_i[7:0];
            idx_d    = '0;
            state_d  = StWrReg;
            add_d    = RegBase;
            wen_d    = 1'b0;
            data_d   = regs_q[0];
          end
        end
      end
      StRetry: begin
        if (cnt_q == LastCnt) begin
          state_d = StAcqReq;
          add_d   = AcqAddr;
          wen_d   = 1'b1;
          data_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrReg: begin
        if (periph_gnt_i) begin
          if (idx_q == LastIdx) begin
            state_d = StTrigger;
            add_d   = TrigAddr;
            data_d  = 32'h0;
          end else begin
            idx_d  = idx_nxt;
            add_d  = RegBase + (32'(idx_nxt) << 2);
            data_d = regs_q[idx_nxt];
          end
        end
      end
      StTrigger: begin
        if (periph_gnt_i) state_d = StWaitEvt;
      end
      StWaitEvt: begin
        if (evt_i) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    req_d  = (state_d == StAcqReq) || (state_d == StWrReg) || (state_d == StTrigger);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      regs_q   <= '0;
      req_q    <= 1'b0;
      add_q    <= 32'h0;
      wen_q    <= 1'b1;
      data_q   <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      job_id_q <= 8'h0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      regs_q   <= regs_d;
      req_q    <= req_d;
      add_q    <= add_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      job_id_q <= job_id_d;
    end
  end

  assign periph_req_o  = req_q;
  assign periph_add_o  = add_q;
  assign periph_wen_o  = wen_q;
  assign periph_be_o   = 4'hF;
  assign periph_data_o = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign job_id_o      = job_id_q;

endmodule

// File: tb/tb_accelerator_job_launcher.sv
// Directed bench: a small bus target model grants requests, answers ACQUIRE
// reads one cycle after grant and logs every completed write for checking.
module tb_accelerator_job_launcher;

  localparam int NR = 13;
  localparam int RW = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [NR*32-1:0]  job_regs_i;
  logic              evt_i;
  logic              periph_req_o;
  logic              periph_gnt_i;
  logic [31:0]       periph_add_o;
  logic              periph_wen_o;
  logic [3:0]        periph_be_o;
  logic [31:0]       periph_data_o;
  logic [31:0]       periph_r_data_i;
  logic              periph_r_valid_i;
  logic              busy_o;
  logic              done_o;
  logic [7:0]        job_id_o;

  accelerator_job_launcher #(
    .BASE_ADDR  (32'h0000_0000),
    .N_REGS     (NR),
    .RETRY_WAIT (RW)
  ) u_dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .job_regs_i       (job_regs_i),
    .evt_i            (evt_i),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_r_data_i  (periph_r_data_i),
    .periph_r_valid_i (periph_r_valid_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .job_id_o         (job_id_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  logic [31:0] wr_add[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  int          rv_cyc[$];
  logic [31:0] acq_resp[$];
  bit          rv_arm;
  int          evt_a, evt_b;
  logic [31:0] stall_addr;
  int          stall_left, hold_cnt, stable_err;
  bit          prev_stall;
  logic [31:0] prev_add, prev_data;
  logic        prev_wen;
  bit          done_seen;
  int          done_cyc, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_add.delete(); wr_data.delete(); wr_cyc.delete();
    rd_cyc.delete(); rv_cyc.delete(); acq_resp.delete();
    rv_arm = 0; evt_a = -1; evt_b = -1;
    stall_addr = 32'hFFFF_FFFF; stall_left = 0; hold_cnt = 0; stable_err = 0;
    prev_stall = 0; done_seen = 0; done_cyc = -1; done_cnt = 0;
  endtask

  // One cycle of the target model, run at the falling edge
  task automatic bus_model();
    if (rv_arm) begin
      periph_r_valid_i = 1'b1;
      periph_r_data_i  = (acq_resp.size() > 0) ? acq_resp.pop_front() : 32'h8000_0000;
      rv_cyc.push_back(cyc);
    end else begin
      periph_r_valid_i = 1'b0;
      periph_r_data_i  = 32'h8000_00AA;
    end
    rv_arm = 0;
    if (prev_stall && (!periph_req_o || periph_add_o != prev_add ||
                       periph_data_o != prev_data || periph_wen_o != prev_wen))
      stable_err++;
    periph_gnt_i = 1'b1;
    if (periph_req_o && !periph_wen_o && periph_add_o == stall_addr) begin
      hold_cnt++;
      if (stall_left > 0) begin
        periph_gnt_i = 1'b0;
        stall_left--;
      end
    end
    if (periph_req_o && periph_gnt_i) begin
      if (periph_wen_o) begin
        rd_cyc.push_back(cyc);
        rv_arm = 1;
      end else begin
        wr_add.push_back(periph_add_o);
        wr_data.push_back(periph_data_o);
        wr_cyc.push_back(cyc);
      end
    end
    prev_stall = periph_req_o && !periph_gnt_i;
    prev_add   = periph_add_o;
    prev_data  = periph_data_o;
    prev_wen   = periph_wen_o;
    evt_i = (cyc == evt_a) || (cyc == evt_b);
    if (done_o) begin
      done_seen = 1;
      done_cyc  = cyc;
      done_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    bus_model();
  endtask

  task automatic launch(input logic [NR*32-1:0] regs);
    @(negedge clk);
    cyc        = 0;
    start_i    = 1'b1;
    job_regs_i = regs;
    bus_model();
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_job(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_seen), 32'd1);
  endtask

  function automatic logic [NR*32-1:0] pat(input logic [31:0] seed);
    logic [NR*32-1:0] r;
    for (int i = 0; i < NR; i++) r[32*i+:32] = seed + 32'(i) * 32'h0101_0101;
    return r;
  endfunction

  // Expected write log: NR register writes then the trigger write
  task automatic check_writes(input string tag, input logic [31:0] seed, input int first,
                              input int stall_at, input int stall_n);
    check({tag, "_nwr"}, 32'(wr_add.size()), 32'(NR + 1));
    if (wr_add.size() == NR + 1) begin
      for (int i = 0; i < NR; i++) begin
        check($sformatf("%s_add%0d", tag, i), wr_add[i], 32'h40 + 32'(4 * i));
        check($sformatf("%s_dat%0d", tag, i), wr_data[i], seed + 32'(i) * 32'h0101_0101);
        check($sformatf("%s_cyc%0d", tag, i), 32'(wr_cyc[i]),
              32'(first + i + ((i >= stall_at) ? stall_n : 0)));
      end
      check({tag, "_trig_add"}, wr_add[NR], 32'h0);
      check({tag, "_trig_dat"}, wr_data[NR], 32'h0);
      check({tag, "_trig_cyc"}, 32'(wr_cyc[NR]), 32'(first + NR + stall_n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; job_regs_i = '0; evt_i = 1'b0;
    periph_gnt_i = 1'b1; periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0;
    cyc = 0;
    clear_log();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", 32'(periph_req_o), 32'd0);
    check("rst_add", periph_add_o, 32'h0);
    check("rst_wen", 32'(periph_wen_o), 32'd1);
    check("rst_data", periph_data_o, 32'h0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_jobid", 32'(job_id_o), 32'd0);
    check("be", 32'(periph_be_o), 32'hF);
    rst_i = 1'b0;
    repeat (2) tick();

    // Nominal job
    clear_log();
    acq_resp.push_back(32'h0000_0002);
    evt_a = 30;
    launch(pat(32'hA000_0000));
    check("nom_busy1", 32'(busy_o), 32'd1);
    check("nom_req1", 32'(periph_req_o), 32'd1);
    check("nom_add1", periph_add_o, 32'h4);
    check("nom_wen1", 32'(periph_wen_o), 32'd1);
    run_job(60);
    check("nom_rd_n", 32'(rd_cyc.size()), 32'd1);
    check("nom_rd_cyc", 32'(rd_cyc[0]), 32'd1);
    check("nom_rv_cyc", 32'(rv_cyc[0]), 32'd2);
    check_writes("nom", 32'hA000_0000, 3, NR, 0);
    check("nom_done_cyc", 32'(done_cyc), 32'd31);
    check("nom_jobid", 32'(job_id_o), 32'd2);
    tick();
    check("nom_done_pulse", 32'(done_o), 32'd0);
    check("nom_busy_fall", 32'(busy_o), 32'd0);
    check("nom_done_cnt", 32'(done_cnt), 32'd1);

    // Busy slot: one retry, job ID held until the successful ACQUIRE
    clear_log();
    acq_resp.push_back(32'hFFFF_FFFF);
    acq_resp.push_back(32'h0000_0001);
    evt_a = 35;
    launch(pat(32'hB000_0000));
    while (cyc < 5) tick();
    check("busy_jobid_held", 32'(job_id_o), 32'd2);
    check("busy_req_retry", 32'(periph_req_o), 32'd0);
    run_job(80);
    check("busy_rd_n", 32'(rd_cyc.size()), 32'd2);
    check("busy_rd2_cyc", 32'(rd_cyc[1]), 32'd11);
    check("busy_gap", 32'(rd_cyc[1] - rv_cyc[0] - 1), 32'(RW));
    check_writes("busy", 32'hB000_0000, 13, NR, 0);
    check("busy_done_cyc", 32'(done_cyc), 32'd36);
    check("busy_jobid", 32'(job_id_o), 32'd1);
    tick();

    // Grant stalls on register 5, with start pulses and new job_regs_i while busy
    clear_log();
    acq_resp.push_back(32'h0000_0003);
    stall_addr = 32'h54;
    stall_left = 3;
    evt_a = 25;
    launch(pat(32'hC000_0000));
    repeat (8) begin
      tick();
      start_i    = (cyc % 2 == 0);
      job_regs_i = pat(32'h5555_0000);
    end
    start_i = 1'b0;
    run_job(60);
    check("stall_hold", 32'(hold_cnt), 32'd4);
    check("stall_stable", 32'(stable_err), 32'd0);
    check("stall_rd_n", 32'(rd_cyc.size()), 32'd1);
    check_writes("stall", 32'hC000_0000, 3, 5, 3);
    check("stall_done_cyc", 32'(done_cyc), 32'd26);
    check("stall_jobid", 32'(job_id_o), 32'd3);
    tick();

    // Reset while writing register 7, then a fresh job
    clear_log();
    acq_resp.push_back(32'h0000_0006);
    launch(pat(32'hD000_0000));
    while (cyc < 10) tick();
    check("rstmid_add_pre", periph_add_o, 32'h5C);
    rst_i = 1'b1;
    #1;
    check("rstmid_req", 32'(periph_req_o), 32'd0);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_jobid", 32'(job_id_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (2) tick();
    clear_log();
    acq_resp.push_back(32'h0000_0004);
    evt_a = 20;
    launch(pat(32'hE000_0000));
    run_job(60);
    check("rstmid_rd_n", 32'(rd_cyc.size()), 32'd1);
    check_writes("rerun", 32'hE000_0000, 3, NR, 0);
    check("rerun_jobid", 32'(job_id_o), 32'd4);
    tick();

    // Early event during TRIGGER is lost; only the later one completes the job
    clear_log();
    acq_resp.push_back(32'h0000_0005);
    evt_a = 16;
    evt_b = 22;
    launch(pat(32'hF000_0000));
    run_job(60);
    check("early_done_cyc", 32'(done_cyc), 32'd23);
    check("early_done_cnt", 32'(done_cnt), 32'd1);
    check("early_jobid", 32'(job_id_o), 32'd5);
    check("early_trig_cyc", 32'(wr_cyc[NR]), 32'd16);
    tick();
    check("early_busy_fall", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
